// File: rtl/framebuffer.sv
// Double-buffered 16-bit framebuffer: GPU writes land in the back bank while the
// front bank is streamed in raster order; bank swaps happen only between frames.
module framebuffer #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(FB_WIDTH):0]    fb_x,
  input  logic [$clog2(FB_HEIGHT):0]   fb_y,
  input  logic [15:0]                  fb_color,
  input  logic                         fb_write,
  input  logic                         swap_request,
  output logic                         swap_pending,
  output logic                         swap_done,
  input  logic                         scan_start,
  output logic                         scan_busy,
  output logic [15:0]                  scan_color,
  output logic                         scan_valid,
  input  logic                         scan_ready,
  output logic                         scan_last
);

  localparam int unsigned DEPTH = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned XW    = $clog2(FB_WIDTH) + 1;
  localparam int unsigned YW    = $clog2(FB_HEIGHT) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [15:0]   mem [2][DEPTH];
  logic [15:0]   rd_data_q;

  logic [0:0]    state_q, state_d;
  logic          front_sel_q, front_sel_d;
  logic          swap_pend_q, swap_pend_d;
  logic          swap_done_q, swap_done_d;
  logic          swap_req_q, scan_start_q;
  logic [XW-1:0] rx_q, rx_d;
  logic [YW-1:0] ry_q, ry_d;
  logic          issued_all_q, issued_all_d;
  logic          rd_vld_q, rd_last_q;
  logic [15:0]   fifo_color_q [2];
  logic [15:0]   fifo_color_d [2];
  logic          fifo_last_q [2];
  logic          fifo_last_d [2];
  logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;

  logic          swap_edge, scan_edge, swap_exec;
  logic          wr_en, rd_en, rd_last;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          bypass, pop, push, pop_fifo, head_last;
  logic [15:0]   head_color;

  assign swap_edge = swap_request && !swap_req_q;
  assign scan_edge = scan_start && !scan_start_q;
  assign swap_exec = swap_pend_q && (state_q == IDLE);

  assign wr_en   = fb_write && (fb_x < XW'(FB_WIDTH)) && (fb_y < YW'(FB_HEIGHT));
  assign wr_addr = AW'(32'(fb_y) * 32'(FB_WIDTH) + 32'(fb_x));
  assign rd_addr = AW'(32'(ry_q) * 32'(FB_WIDTH) + 32'(rx_q));
  assign rd_last = (rx_q == XW'(FB_WIDTH - 1)) && (ry_q == YW'(FB_HEIGHT - 1));

  // The RAM output register acts as a bypass stage in front of the FIFO so the
  // first pixel is valid one cycle after its read issues.
  assign rd_en = (state_q == RUN) && !issued_all_q && ((cnt_q + 2'(rd_vld_q)) < 2'd2);

  assign bypass     = (cnt_q == 2'd0);
  assign head_color = bypass ? rd_data_q : fifo_color_q[rd_ptr_q];
  assign head_last  = bypass ? rd_last_q : fifo_last_q[rd_ptr_q];
  assign scan_valid = !bypass || rd_vld_q;
  assign scan_color = scan_valid ? head_color : '0;
  assign scan_last  = scan_valid && head_last;
  assign pop        = scan_valid && scan_ready;
  assign pop_fifo   = pop && !bypass;
  assign push       = rd_vld_q && !(bypass && pop);

  assign scan_busy    = (state_q == RUN);
  assign swap_pending = swap_pend_q;
  assign swap_done    = swap_done_q;

  // Bank select is taken from the current front_sel, so a write coinciding with
  // a swap still lands in the pre-swap back bank.
  always_ff @(posedge clk) begin
    if (wr_en) mem[!front_sel_q][wr_addr] <= fb_color;
    if (rd_en) rd_data_q <= mem[front_sel_q][rd_addr];
  end

  always_comb begin
    state_d      = state_q;
    front_sel_d  = front_sel_q;
    swap_pend_d  = swap_pend_q;
    swap_done_d  = 1'b0;
    rx_d         = rx_q;
    ry_d         = ry_q;
    issued_all_d = issued_all_q;
    fifo_color_d = fifo_color_q;
    fifo_last_d  = fifo_last_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q + 2'(push) - 2'(pop_fifo);

    if (swap_exec) begin
      front_sel_d = !front_sel_q;
      swap_pend_d = 1'b0;
      swap_done_d = 1'b1;
    end else if (swap_edge) begin
      swap_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (scan_edge) begin
          state_d      = RUN;
          rx_d         = '0;
          ry_d         = '0;
          issued_all_d = 1'b0;
        end
      end
      default: begin
        if (rd_en) begin
          if (rd_last) begin
            issued_all_d = 1'b1;
          end else if (rx_q == XW'(FB_WIDTH - 1)) begin
            rx_d = '0;
            ry_d = ry_q + 1'b1;
          end else begin
            rx_d = rx_q + 1'b1;
          end
        end
        if (pop && head_last) state_d = IDLE;
      end
    endcase

    if (pop_fifo) rd_ptr_d = !rd_ptr_q;
    if (push) begin
      fifo_color_d[wr_ptr_q] = rd_data_q;
      fifo_last_d[wr_ptr_q]  = rd_last_q;
      wr_ptr_d               = !wr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      front_sel_q  <= 1'b0;
      swap_pend_q  <= 1'b0;
      swap_done_q  <= 1'b0;
      swap_req_q   <= 1'b0;
      scan_start_q <= 1'b0;
      rx_q         <= '0;
      ry_q         <= '0;
      issued_all_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cnt_q        <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_color_q[i] <= '0;
        fifo_last_q[i]  <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      front_sel_q  <= front_sel_d;
      swap_pend_q  <= swap_pend_d;
      swap_done_q  <= swap_done_d;
      swap_req_q   <= swap_request;
      scan_start_q <= scan_start;
      rx_q         <= rx_d;
      ry_q         <= ry_d;
      issued_all_q <= issued_all_d;
      rd_vld_q     <= rd_en;
      rd_last_q    <= rd_last;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      fifo_color_q <= fifo_color_d;
      fifo_last_q  <= fifo_last_d;
    end
  end

endmodule
